// File: rtl/bist_pkg.sv
//==============================================================================
// bist_pkg : shared types and constants for the logic-BIST session controller
// Rev 1.0
//==============================================================================
`default_nettype none

package bist_pkg;

   localparam int N_DEF     = 8;
   localparam int CNT_W_DEF = 16;
   localparam int LAT_MAX   = 15;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEED    = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      COMPARE = 3'd4
   } bist_state_t;

endpackage

`default_nettype wire

// File: rtl/bist_controller_if.sv
//==============================================================================
// bist_controller_if : session control, TPG/MISR drive and result signals
// Rev 1.0
//==============================================================================
`default_nettype none

interface bist_controller_if #(
   parameter int N     = bist_pkg::N_DEF,
   parameter int CNT_W = bist_pkg::CNT_W_DEF
);

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] num_patterns;
   logic [N-1:0]     golden;
   logic [N-1:0]     misr_sig;
   logic             tpg_rst;
   logic             tpg_en;
   logic             misr_en;
   logic             test_mode;
   logic             busy;
   logic             done;
   logic             pass;
   logic [N-1:0]     fail_sig;

   modport master (
      output start, abort, num_patterns, golden, misr_sig,
      input  tpg_rst, tpg_en, misr_en, test_mode, busy, done, pass, fail_sig
   );

   modport slave (
      input  start, abort, num_patterns, golden, misr_sig,
      output tpg_rst, tpg_en, misr_en, test_mode, busy, done, pass, fail_sig
   );

endinterface

`default_nettype wire

// File: rtl/en_delay.sv
//==============================================================================
// en_delay : LAT-stage enable shift register, cleared by rst or clr
// Rev 1.0
//==============================================================================
`default_nettype none

module en_delay #(
   parameter int LAT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en_in,
   output logic en_out
);

   generate
      if (LAT == 0) begin : g_bypass
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, clr};
         assign en_out     = en_in;
      end else begin : g_shift
         logic [LAT-1:0] stages;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               stages <= '0;
            end else begin
               stages[0] <= en_in;
               for (int i = 1; i < LAT; i++) begin
                  stages[i] <= stages[i-1];
               end
            end
         end

         assign en_out = stages[LAT-1];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/bist_controller.sv
//==============================================================================
// bist_controller : sequences seed, pattern run, drain and signature compare
// Rev 1.0
//==============================================================================
`default_nettype none

import bist_pkg::*;

module bist_controller #(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int LAT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   bist_controller_if.slave  bus
);

   localparam int            DRAIN_W    = $clog2(LAT_MAX + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = (LAT > 0) ? DRAIN_W'(LAT - 1) : '0;

   bist_state_t        state;
   bist_state_t        state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [N-1:0]       golden_q;
   logic [N-1:0]       fail_sig_q;
   logic               pass_q;
   logic               done_q;
   logic               abort_act;
   logic               tpg_en_int;

   assign abort_act = bus.abort && (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SEED;
         SEED:    state_nxt = (cnt == '0) ? COMPARE : RUN;
         RUN: begin
            if (cnt == CNT_W'(1)) state_nxt = (LAT > 0) ? DRAIN : COMPARE;
         end
         DRAIN:   if (drain_cnt == '0) state_nxt = COMPARE;
         COMPARE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Abort overrides whatever transition the session would otherwise take.
      if (abort_act) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         drain_cnt  <= '0;
         golden_q   <= '0;
         fail_sig_q <= '0;
         pass_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == COMPARE) && !abort_act;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  cnt      <= bus.num_patterns;
                  golden_q <= bus.golden;
                  pass_q   <= 1'b0;
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) drain_cnt <= DRAIN_INIT;
            end
            DRAIN: begin
               if (drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
            COMPARE: begin
               if (!abort_act) begin
                  pass_q     <= (bus.misr_sig == golden_q);
                  fail_sig_q <= bus.misr_sig;
               end
            end
            default: ;
         endcase
      end
   end

   assign tpg_en_int = (state == RUN);

   en_delay #(
      .LAT (LAT)
   ) u_en_delay (
      .clk    (clk),
      .rst    (rst),
      .clr    (abort_act),
      .en_in  (tpg_en_int),
      .en_out (bus.misr_en)
   );

   assign bus.tpg_rst   = (state == SEED);
   assign bus.tpg_en    = tpg_en_int;
   assign bus.busy      = (state != IDLE);
   assign bus.test_mode = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail_sig  = fail_sig_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_controller.sv
//==============================================================================
// tb_bist_controller : directed timeline checks on LAT=0 and LAT=2 instances
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_bist_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [5:0] flags;
   logic [5:0] exp;
   logic       s_pass;
   logic [7:0] s_sig;

   always #5 clk = ~clk;

   bist_controller_if #(.N(8), .CNT_W(16)) bus0 ();
   bist_controller_if #(.N(8), .CNT_W(16)) bus1 ();

   bist_controller #(.N(8), .CNT_W(16), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   bist_controller #(.N(8), .CNT_W(16), .LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic st, input logic ab,
                        input logic [15:0] np, input logic [7:0] g, input logic [7:0] sig);
      if (d == 0) begin
         bus0.start = st; bus0.abort = ab; bus0.num_patterns = np;
         bus0.golden = g; bus0.misr_sig = sig;
      end else begin
         bus1.start = st; bus1.abort = ab; bus1.num_patterns = np;
         bus1.golden = g; bus1.misr_sig = sig;
      end
   endtask

   // flags = {tpg_rst, tpg_en, misr_en, busy, test_mode, done}
   task automatic sample(input int d);
      if (d == 0) begin
         flags  = {bus0.tpg_rst, bus0.tpg_en, bus0.misr_en, bus0.busy, bus0.test_mode, bus0.done};
         s_pass = bus0.pass;
         s_sig  = bus0.fail_sig;
      end else begin
         flags  = {bus1.tpg_rst, bus1.tpg_en, bus1.misr_en, bus1.busy, bus1.test_mode, bus1.done};
         s_pass = bus1.pass;
         s_sig  = bus1.fail_sig;
      end
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 16'd0, 8'h00, 8'h00);
      drive(1, 0, 0, 16'd0, 8'h00, 8'h00);
      rst = 1'b1;
      tick(); tick(); tick();
      for (int d = 0; d < 2; d++) begin
         sample(d);
         total++;
         if (flags !== 6'b0 || s_pass !== 1'b0 || s_sig !== 8'h00) begin
            bad++;
            $display("FAIL reset dut%0d flags=%b pass=%b sig=%h want 000000/0/00", d, flags, s_pass, s_sig);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lat0_pass();
      drive(0, 1, 0, 16'd3, 8'h3C, 8'h3C);
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) bus0.start = 1'b0;
         sample(0);
         exp = {c == 1, c >= 2 && c <= 4, c >= 2 && c <= 4, c >= 1 && c <= 5, c >= 1 && c <= 5, c == 6};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL lat0_pass c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 6) begin
            total++;
            if (s_pass !== 1'b1 || s_sig !== 8'h3C) begin
               bad++;
               $display("FAIL lat0_pass result pass=%b sig=%h want 1/3c", s_pass, s_sig);
            end
         end
      end
   endtask

   task automatic test_lat2_fail();
      drive(1, 1, 0, 16'd3, 8'hA5, 8'h5A);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) bus1.start = 1'b0;
         sample(1);
         exp = {c == 1, c >= 2 && c <= 4, c >= 4 && c <= 6, c >= 1 && c <= 7, c >= 1 && c <= 7, c == 8};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL lat2_fail c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 8) begin
            total++;
            if (s_pass !== 1'b0 || s_sig !== 8'h5A) begin
               bad++;
               $display("FAIL lat2_fail result pass=%b sig=%h want 0/5a", s_pass, s_sig);
            end
         end
      end
   endtask

   task automatic test_zero_patterns();
      drive(0, 1, 0, 16'd0, 8'h01, 8'h01);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) bus0.start = 1'b0;
         sample(0);
         exp = {c == 1, 1'b0, 1'b0, c >= 1 && c <= 2, c >= 1 && c <= 2, c == 3};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL zero_pat c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 3) begin
            total++;
            if (s_pass !== 1'b1 || s_sig !== 8'h01) begin
               bad++;
               $display("FAIL zero_pat result pass=%b sig=%h want 1/01", s_pass, s_sig);
            end
         end
      end
   endtask

   task automatic test_abort();
      // LAT=0 instance, abort sampled at the end of cycle 3.
      drive(0, 1, 0, 16'd10, 8'h3C, 8'h3C);
      for (int c = 1; c <= 15; c++) begin
         tick();
         sample(0);
         exp = {c == 1, c >= 2 && c <= 3, c >= 2 && c <= 3, c >= 1 && c <= 3, c >= 1 && c <= 3, 1'b0};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL abort0 c=%0d flags got=%b want=%b", c, flags, exp);
         end
         bus0.start = 1'b0;
         bus0.abort = (c == 3);
      end
      total++;
      if (s_pass !== 1'b0) begin
         bad++;
         $display("FAIL abort0 pass got=%b want=0", s_pass);
      end
      // LAT=2 instance, abort at end of cycle 4 must flush the pending enables.
      drive(1, 1, 0, 16'd10, 8'h5A, 8'h5A);
      for (int c = 1; c <= 14; c++) begin
         tick();
         sample(1);
         exp = {c == 1, c >= 2 && c <= 4, c == 4, c >= 1 && c <= 4, c >= 1 && c <= 4, 1'b0};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL abort2 c=%0d flags got=%b want=%b", c, flags, exp);
         end
         bus1.start = 1'b0;
         bus1.abort = (c == 4);
      end
      total++;
      if (s_pass !== 1'b0) begin
         bad++;
         $display("FAIL abort2 pass got=%b want=0", s_pass);
      end
   endtask

   task automatic test_back_to_back();
      drive(0, 1, 0, 16'd2, 8'h77, 8'h77);
      for (int c = 1; c <= 10; c++) begin
         tick();
         sample(0);
         exp = {c == 1 || c == 6,
                (c >= 2 && c <= 3) || c == 7,
                (c >= 2 && c <= 3) || c == 7,
                (c >= 1 && c <= 4) || (c >= 6 && c <= 8),
                (c >= 1 && c <= 4) || (c >= 6 && c <= 8),
                c == 5 || c == 9};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL b2b c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 5 || c == 6 || c == 9) begin
            total++;
            if (s_pass !== (c == 5) || s_sig !== 8'h77) begin
               bad++;
               $display("FAIL b2b result c=%0d pass=%b sig=%h want %b/77", c, s_pass, s_sig, c == 5);
            end
         end
         case (c)
            2:       drive(0, 1, 0, 16'd9, 8'hFF, 8'h77);
            5:       drive(0, 1, 0, 16'd1, 8'h11, 8'h77);
            default: bus0.start = 1'b0;
         endcase
      end
   endtask

   task automatic test_rst_mid_drain();
      drive(1, 1, 0, 16'd3, 8'hA5, 8'h5A);
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) bus1.start = 1'b0;
         sample(1);
         if (c <= 5)
            exp = {c == 1, c >= 2 && c <= 4, c >= 4 && c <= 5, 1'b1, 1'b1, 1'b0};
         else
            exp = 6'b0;
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL rst_drain c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 5) rst = 1'b1;
      end
      total++;
      if (s_pass !== 1'b0 || s_sig !== 8'h00) begin
         bad++;
         $display("FAIL rst_drain cleared pass=%b sig=%h want 0/00", s_pass, s_sig);
      end
      rst = 1'b0;
      drive(1, 1, 0, 16'd1, 8'hC3, 8'hC3);
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) bus1.start = 1'b0;
         sample(1);
         exp = {c == 1, c == 2, c == 4, c >= 1 && c <= 5, c >= 1 && c <= 5, c == 6};
         total++;
         if (flags !== exp) begin
            bad++;
            $display("FAIL rst_fresh c=%0d flags got=%b want=%b", c, flags, exp);
         end
         if (c == 6) begin
            total++;
            if (s_pass !== 1'b1 || s_sig !== 8'hC3) begin
               bad++;
               $display("FAIL rst_fresh result pass=%b sig=%h want 1/c3", s_pass, s_sig);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lat0_pass();
      tick();
      test_lat2_fail();
      tick();
      test_zero_patterns();
      tick();
      test_abort();
      tick();
      test_back_to_back();
      tick(); tick();
      test_rst_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bist_controller.md
# bist_controller

Sequencing controller for one logic-BIST session. It seeds the pattern generator and the signature register, then runs the pattern generator for a programmed number of patterns. The signature-register enable is delayed to match the circuit-under-test latency. At the end it compares the final signature against a golden value and reports pass/fail. It sits directly downstream of the MISR, consuming its `d_out`, and drives the MISR's `rst` and `en`.

## Interface
- `N`, 8, signature width; must equal the MISR `n`
- `CNT_W`, 16, pattern-count width
- `LAT`, 0, CUT pipeline depth in cycles, range 0..15

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin session; sampled only in IDLE
- `abort` in 1: cancel session; sampled in any non-IDLE state
- `num_patterns` in CNT_W: pattern count, latched at start
- `golden` in N: expected signature, latched at start
- `misr_sig` in N: MISR `d_out`
- `tpg_rst` out 1: seed-load pulse to the LFSR and MISR `rst`
- `tpg_en` out 1: pattern-generator advance
- `misr_en` out 1: MISR compaction enable
- `test_mode` out 1: CUT input mux select; high while busy
- `busy` out 1: session in progress
- `done` out 1: one-cycle completion pulse
- `pass` out 1: result; held until the next accepted start
- `fail_sig` out N: signature captured at compare; held

## Operation
- Reset values:
  - state = IDLE.
  - All outputs are 0, and `fail_sig` = 0.
  - Latched count, latched golden value and delay line are cleared.
- States are IDLE, SEED, RUN, DRAIN and COMPARE.
- IDLE:
  - `start`=1 latches `num_patterns` and `golden`, clears `pass`, and moves to SEED.
- SEED, one cycle:
  - `tpg_rst`=1.
  - Next state is RUN, or COMPARE if the latched count is 0.
- RUN:
  - `tpg_en`=1 for exactly `num_patterns` cycles, tracked by a down-counter.
  - On the last cycle, go to DRAIN if `LAT`>0, otherwise to COMPARE.
- DRAIN:
  - Lasts `LAT` cycles. `tpg_en`=0 while the delay line empties.
- `misr_en` is `tpg_en` delayed by exactly `LAT` cycles through a shift register. With `LAT`=0 it equals `tpg_en`.
- COMPARE, one cycle:
  - `misr_sig` is stable here, because the last MISR update happened on the preceding edge.
  - Registers `pass` = (`misr_sig` == latched golden) and `fail_sig` = `misr_sig`.
  - Asserts `done` for the next cycle, and returns to IDLE.
- `busy` = `test_mode` = 1 in every state except IDLE.
- `abort` in a non-IDLE state:
  - Next state is IDLE.
  - `tpg_en`, `misr_en` and the delay line are cleared.
  - No `done` is produced, and `pass` stays 0.
- `start` while busy is ignored.
- `abort` wins over every other transition.
- `rst` mid-session forces the reset values on the next edge, whatever the state.
- `num_patterns` = 0: no enables are issued, and the seed signature is compared.

## Timing
- All outputs are registered or decoded from the registered state; there are no combinational paths from input to output.
- `start` sampled high at the end of cycle 0:
  - cycle 1 is SEED (`tpg_rst`=1);
  - cycles 2..P+1 are RUN (`tpg_en`=1), where P = `num_patterns`;
  - `misr_en` is high in cycles 2+`LAT`..P+1+`LAT`;
  - cycle P+2+`LAT` is COMPARE;
  - cycle P+3+`LAT` has `done`=1, `busy`=0 and `pass` valid.
- `start` may be accepted in the same cycle that `done` is high, because the state is IDLE by then.
- The down-counter is CNT_W bits and never wraps: it reaches 0 exactly at the RUN exit.

## Structure
- Package `bist_pkg` holds:
  - the state enum `bist_state_t` (IDLE, SEED, RUN, DRAIN, COMPARE);
  - the default constants for `N` and `CNT_W`;
  - `LAT_MAX` = 15.
- One sub-module, `en_delay`: a parameterized `LAT`-stage enable shift register with synchronous clear on `rst` or abort, and pass-through when `LAT`=0.

## Test plan
- `LAT`=0, P=3, `golden` equal to the model signature:
  - `tpg_rst` in cycle 1;
  - `tpg_en` = `misr_en` = 1 in cycles 2-4;
  - `done`=1 and `pass`=1 in cycle 6.
- `LAT`=2, P=3, `golden`=8'hA5, final `misr_sig`=8'h5A:
  - `misr_en` in cycles 4-6;
  - `done` in cycle 8 with `pass`=0 and `fail_sig`=8'h5A.
- P=0, `golden` = MISR seed: SEED in cycle 1, COMPARE in cycle 2, `done`=1 and `pass`=1 in cycle 3, with no `tpg_en` or `misr_en` pulses.
- `abort` in cycle 3 of a P=10 run:
  - IDLE in cycle 4, with `tpg_en`=`misr_en`=0;
  - no `done`, `pass`=0.
- `start` re-pulsed during RUN is ignored; `start` in the `done` cycle begins a second session with SEED in the next cycle.
- `rst` asserted mid-DRAIN: next cycle all outputs are 0 and the state is IDLE; a fresh start then completes normally.
